tug_of_war_ctrl: RTL and testbench
==================================

Name: tug_of_war_ctrl

Overview:
- Game controller for the two-player tug-of-war lab.
- Consumes the single-cycle press pulses produced by the button input-processing stage, one pulse per player.
- Moves a one-hot "rope" light across the LED bar and scores rounds.
- Sequences round hold/restart and ends the match at a target score. Its outputs drive the LEDR bar and the HEX score decoders.

Parameters:
- N_POS, 9: number of LED positions; must be odd and >= 3; center C = (N_POS-1)/2.
- WIN_SCORE, 7: rounds needed to win the match; 1..15.
- HOLD_CYCLES, 4: cycles the round-won display is held before the next round; >= 1.
- SCORE_W, $clog2(WIN_SCORE+1): width of each score counter.

Ports:
- clk  in  1  system clock.
- reset_n  in  1  asynchronous, active-low reset.
- p1_press  in  1  player-1 single-cycle press pulse (input-processing out[1]).
- p2_press  in  1  player-2 single-cycle press pulse (input-processing out[0]).
- new_game  in  1  synchronous, active-high pulse; restarts the match.
- leds  out  N_POS  one-hot rope position; bit N_POS-1 is player-1's edge.
- p1_score  out  SCORE_W  player-1 rounds won.
- p2_score  out  SCORE_W  player-2 rounds won.
- winner  out  2  2'b10 = player 1, 2'b01 = player 2, 2'b00 = none.
- round_active  out  1  high while in PLAY.
- match_over  out  1  high while in MATCH_OVER.

Behaviour:
- All outputs are registered. An input sampled at clock edge k is reflected in the outputs after edge k.
- Reset (reset_n low, asynchronous, any state, including mid-hold):
  - state = PLAY, pos = C, leds = one-hot at bit C;
  - scores = 0, winner = 00, hold counter = 0;
  - round_active = 1, match_over = 0.
- Input priority: reset_n > new_game > press inputs. new_game in any state has the same effect as reset, applied at the clock edge.
- Net move each cycle: p1 only = +1; p2 only = -1; both or neither = 0. Simultaneous presses cancel.
- PLAY state:
  - Net 0: no change.
  - Net +1 with pos < N_POS-1: pos += 1. Net -1 with pos > 0: pos -= 1.
  - Net +1 with pos == N_POS-1: player 1 wins the round.
    - p1_score += 1, winner = 10, leds = 0, round_active = 0.
    - If the new p1_score == WIN_SCORE, go to MATCH_OVER.
    - Otherwise go to ROUND_WON with hold counter = HOLD_CYCLES-1.
  - Net -1 with pos == 0: mirror case for player 2 (p2_score, winner = 01).
- ROUND_WON state:
  - Presses are ignored. leds = 0 and winner is held.
  - While counter != 0: counter decrements each cycle.
  - When counter == 0 at an edge: go to PLAY, pos = C, leds = one-hot C, winner = 00, round_active = 1.
  - ROUND_WON therefore lasts exactly HOLD_CYCLES cycles.
- MATCH_OVER state:
  - match_over = 1, leds = 0; winner and scores are held.
  - Presses are ignored. Only new_game or reset exits.
- Scores never exceed WIN_SCORE and never wrap.
- A held button produces only one pulse upstream; this block counts pulses, not levels.
- Undefined or illegal state encodings recover to PLAY with reset values.

Test Plan:
1. Reset with defaults -> leds = 9'b000010000, p1_score = 0, p2_score = 0, winner = 00, round_active = 1, match_over = 0.
2. Four p1_press pulses -> leds = 9'b100000000. Fifth pulse -> leds = 0, winner = 10, p1_score = 1, round_active = 0. Exactly 4 cycles later -> leds = 9'b000010000, winner = 00.
3. p1_press and p2_press high together for 3 cycles -> leds unchanged at center. Then one p2_press pulse -> leds = 9'b000001000.
4. p2 wins a round, then p1_press/p2_press pulses are applied during the 4 hold cycles -> ignored; next round starts at center with scores 0/1.
5. p2 wins 7 rounds -> match_over = 1, winner = 01, p2_score = 7. Further presses change nothing. new_game pulse -> scores 0/0, leds at center, PLAY.
6. reset_n pulled low asynchronously (between edges) during ROUND_WON with p1_score = 3 -> outputs immediately take reset values without waiting for a clock edge.

Source files
------------

// File: rtl/tug_of_war_ctrl.sv
// Tug-of-war game controller.
// Moves a one-hot "rope" light across an LED bar in response to single-cycle
// press pulses from two players, scores rounds, holds the round-won display
// for a fixed number of cycles, and ends the match when one player reaches
// the target score.
//
// Ports:
//   clk          system clock
//   reset_n      asynchronous active-low reset
//   p1_press     player-1 press pulse (moves rope toward bit N_POS-1)
//   p2_press     player-2 press pulse (moves rope toward bit 0)
//   new_game     synchronous restart pulse, same effect as reset
//   leds         one-hot rope position, all zero while a win is displayed
//   p1_score     player-1 rounds won
//   p2_score     player-2 rounds won
//   winner       2'b10 player 1, 2'b01 player 2, 2'b00 none
//   round_active high while a round is being played
//   match_over   high once a player has reached WIN_SCORE
module tug_of_war_ctrl #(
  parameter int unsigned N_POS       = 9,
  parameter int unsigned WIN_SCORE   = 7,
  parameter int unsigned HOLD_CYCLES = 4,
  parameter int unsigned SCORE_W     = $clog2(WIN_SCORE + 1)
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               p1_press,
  input  logic               p2_press,
  input  logic               new_game,
  output logic [N_POS-1:0]   leds,
  output logic [SCORE_W-1:0] p1_score,
  output logic [SCORE_W-1:0] p2_score,
  output logic [1:0]         winner,
  output logic               round_active,
  output logic               match_over
);

  localparam int unsigned C     = (N_POS - 1) / 2;
  localparam int unsigned PosW  = $clog2(N_POS);
  localparam int unsigned HoldW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;

  localparam logic [PosW-1:0]    PosMax   = PosW'(N_POS - 1);
  localparam logic [PosW-1:0]    PosCtr   = PosW'(C);
  localparam logic [N_POS-1:0]   LedCtr   = N_POS'(1) << C;
  localparam logic [HoldW-1:0]   HoldLoad = HoldW'(HOLD_CYCLES - 1);
  localparam logic [SCORE_W-1:0] LastWin  = SCORE_W'(WIN_SCORE - 1);

  typedef enum logic [1:0] {
    StPlay      = 2'b00,
    StRoundWon  = 2'b01,
    StMatchOver = 2'b10
  } state_e;

  state_e           state;
  logic [PosW-1:0]  pos;
  logic [HoldW-1:0] hold_cnt;

  // Simultaneous presses cancel out.
  logic move_up, move_dn, state_bad;
  assign move_up   = p1_press & ~p2_press;
  assign move_dn   = p2_press & ~p1_press;
  assign state_bad = !(state inside {StPlay, StRoundWon, StMatchOver});

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state        <= StPlay;
      pos          <= PosCtr;
      hold_cnt     <= '0;
      leds         <= LedCtr;
      p1_score     <= '0;
      p2_score     <= '0;
      winner       <= 2'b00;
      round_active <= 1'b1;
      match_over   <= 1'b0;
    end else if (new_game || state_bad) begin
      // Restart and illegal-encoding recovery both land on the reset values.
      state        <= StPlay;
      pos          <= PosCtr;
      hold_cnt     <= '0;
      leds         <= LedCtr;
      p1_score     <= '0;
      p2_score     <= '0;
      winner       <= 2'b00;
      round_active <= 1'b1;
      match_over   <= 1'b0;
    end else begin
      case (state)
        StPlay: begin
          if (move_up) begin
            if (pos == PosMax) begin
              p1_score     <= p1_score + SCORE_W'(1);
              winner       <= 2'b10;
              leds         <= '0;
              round_active <= 1'b0;
              if (p1_score == LastWin) begin
                state      <= StMatchOver;
                match_over <= 1'b1;
              end else begin
                state    <= StRoundWon;
                hold_cnt <= HoldLoad;
              end
            end else begin
              pos  <= pos + PosW'(1);
              leds <= leds << 1;
            end
          end else if (move_dn) begin
            if (pos == '0) begin
              p2_score     <= p2_score + SCORE_W'(1);
              winner       <= 2'b01;
              leds         <= '0;
              round_active <= 1'b0;
              if (p2_score == LastWin) begin
                state      <= StMatchOver;
                match_over <= 1'b1;
              end else begin
                state    <= StRoundWon;
                hold_cnt <= HoldLoad;
              end
            end else begin
              pos  <= pos - PosW'(1);
              leds <= leds >> 1;
            end
          end
        end
        StRoundWon: begin
          // Loaded with HOLD_CYCLES-1, so the hold spans HOLD_CYCLES cycles.
          if (hold_cnt != '0) begin
            hold_cnt <= hold_cnt - HoldW'(1);
          end else begin
            state        <= StPlay;
            pos          <= PosCtr;
            leds         <= LedCtr;
            winner       <= 2'b00;
            round_active <= 1'b1;
          end
        end
        StMatchOver: begin
          // Terminal until new_game or reset.
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_tug_of_war_ctrl.sv
module tb_tug_of_war_ctrl;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       p1_press;
  logic       p2_press;
  logic       new_game;
  logic [8:0] leds;
  logic [2:0] p1_score;
  logic [2:0] p2_score;
  logic [1:0] winner;
  logic       round_active;
  logic       match_over;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  tug_of_war_ctrl #(
    .N_POS      (9),
    .WIN_SCORE  (7),
    .HOLD_CYCLES(4),
    .SCORE_W    (3)
  ) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .p1_press    (p1_press),
    .p2_press    (p2_press),
    .new_game    (new_game),
    .leds        (leds),
    .p1_score    (p1_score),
    .p2_score    (p2_score),
    .winner      (winner),
    .round_active(round_active),
    .match_over  (match_over)
  );

  typedef struct {
    logic       p1;
    logic       p2;
    logic       ng;
    logic [8:0] leds;
    logic [2:0] s1;
    logic [2:0] s2;
    logic [1:0] win;
    logic       ra;
    logic       mo;
  } vec_t;

  localparam int NVec = 24;
  vec_t vecs[NVec];

  task automatic check(input string name, input logic [8:0] el, input logic [2:0] e1,
                       input logic [2:0] e2, input logic [1:0] ew, input logic era,
                       input logic emo);
    logic [18:0] act;
    logic [18:0] exp;
    act = {leds, p1_score, p2_score, winner, round_active, match_over};
    exp = {el, e1, e2, ew, era, emo};
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got leds=%b p1=%0d p2=%0d win=%b ra=%b mo=%b, want leds=%b p1=%0d p2=%0d win=%b ra=%b mo=%b",
               name, leds, p1_score, p2_score, winner, round_active, match_over,
               el, e1, e2, ew, era, emo);
    end
  endtask

  // Apply inputs for one clock edge, then sample 1 time unit after the edge.
  task automatic step(input logic a, input logic b, input logic g);
    p1_press = a;
    p2_press = b;
    new_game = g;
    @(posedge clk);
    #1;
    p1_press = 1'b0;
    p2_press = 1'b0;
    new_game = 1'b0;
  endtask

  localparam logic [8:0] Ctr = 9'b000010000;

  initial begin
    // p1 drives the rope to its edge and wins, then the 4-cycle hold.
    vecs[0]  = '{1'b1, 1'b0, 1'b0, 9'b000100000, 3'd0, 3'd0, 2'b00, 1'b1, 1'b0};
    vecs[1]  = '{1'b1, 1'b0, 1'b0, 9'b001000000, 3'd0, 3'd0, 2'b00, 1'b1, 1'b0};
    vecs[2]  = '{1'b1, 1'b0, 1'b0, 9'b010000000, 3'd0, 3'd0, 2'b00, 1'b1, 1'b0};
    vecs[3]  = '{1'b1, 1'b0, 1'b0, 9'b100000000, 3'd0, 3'd0, 2'b00, 1'b1, 1'b0};
    vecs[4]  = '{1'b1, 1'b0, 1'b0, 9'b000000000, 3'd1, 3'd0, 2'b10, 1'b0, 1'b0};
    vecs[5]  = '{1'b0, 1'b0, 1'b0, 9'b000000000, 3'd1, 3'd0, 2'b10, 1'b0, 1'b0};
    vecs[6]  = '{1'b0, 1'b0, 1'b0, 9'b000000000, 3'd1, 3'd0, 2'b10, 1'b0, 1'b0};
    vecs[7]  = '{1'b0, 1'b0, 1'b0, 9'b000000000, 3'd1, 3'd0, 2'b10, 1'b0, 1'b0};
    vecs[8]  = '{1'b0, 1'b0, 1'b0, Ctr,          3'd1, 3'd0, 2'b00, 1'b1, 1'b0};
    // Simultaneous presses cancel; then a single p2 step.
    vecs[9]  = '{1'b1, 1'b1, 1'b0, Ctr,          3'd1, 3'd0, 2'b00, 1'b1, 1'b0};
    vecs[10] = '{1'b1, 1'b1, 1'b0, Ctr,          3'd1, 3'd0, 2'b00, 1'b1, 1'b0};
    vecs[11] = '{1'b1, 1'b1, 1'b0, Ctr,          3'd1, 3'd0, 2'b00, 1'b1, 1'b0};
    vecs[12] = '{1'b0, 1'b1, 1'b0, 9'b000001000, 3'd1, 3'd0, 2'b00, 1'b1, 1'b0};
    // new_game beats a concurrent press.
    vecs[13] = '{1'b1, 1'b0, 1'b1, Ctr,          3'd0, 3'd0, 2'b00, 1'b1, 1'b0};
    // p2 wins; presses during the hold are ignored.
    vecs[14] = '{1'b0, 1'b1, 1'b0, 9'b000001000, 3'd0, 3'd0, 2'b00, 1'b1, 1'b0};
    vecs[15] = '{1'b0, 1'b1, 1'b0, 9'b000000100, 3'd0, 3'd0, 2'b00, 1'b1, 1'b0};
    vecs[16] = '{1'b0, 1'b1, 1'b0, 9'b000000010, 3'd0, 3'd0, 2'b00, 1'b1, 1'b0};
    vecs[17] = '{1'b0, 1'b1, 1'b0, 9'b000000001, 3'd0, 3'd0, 2'b00, 1'b1, 1'b0};
    vecs[18] = '{1'b0, 1'b1, 1'b0, 9'b000000000, 3'd0, 3'd1, 2'b01, 1'b0, 1'b0};
    vecs[19] = '{1'b1, 1'b0, 1'b0, 9'b000000000, 3'd0, 3'd1, 2'b01, 1'b0, 1'b0};
    vecs[20] = '{1'b0, 1'b1, 1'b0, 9'b000000000, 3'd0, 3'd1, 2'b01, 1'b0, 1'b0};
    vecs[21] = '{1'b1, 1'b1, 1'b0, 9'b000000000, 3'd0, 3'd1, 2'b01, 1'b0, 1'b0};
    vecs[22] = '{1'b1, 1'b0, 1'b0, Ctr,          3'd0, 3'd1, 2'b00, 1'b1, 1'b0};
    vecs[23] = '{1'b0, 1'b0, 1'b0, Ctr,          3'd0, 3'd1, 2'b00, 1'b1, 1'b0};

    reset_n  = 1'b0;
    p1_press = 1'b0;
    p2_press = 1'b0;
    new_game = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_state", Ctr, 3'd0, 3'd0, 2'b00, 1'b1, 1'b0);
    reset_n = 1'b1;

    for (int i = 0; i < NVec; i++) begin
      step(vecs[i].p1, vecs[i].p2, vecs[i].ng);
      check($sformatf("vec%0d", i), vecs[i].leds, vecs[i].s1, vecs[i].s2, vecs[i].win,
            vecs[i].ra, vecs[i].mo);
    end

    // p2 takes rounds 2..7 and ends the match.
    for (int r = 2; r <= 7; r++) begin
      repeat (5) step(1'b0, 1'b1, 1'b0);
      if (r < 7) begin
        check($sformatf("p2_round%0d", r), 9'd0, 3'd0, 3'(r), 2'b01, 1'b0, 1'b0);
        repeat (4) step(1'b0, 1'b0, 1'b0);
        check($sformatf("p2_restart%0d", r), Ctr, 3'd0, 3'(r), 2'b00, 1'b1, 1'b0);
      end else begin
        check("match_over", 9'd0, 3'd0, 3'd7, 2'b01, 1'b0, 1'b1);
      end
    end
    repeat (3) step(1'b1, 1'b0, 1'b0);
    repeat (3) step(1'b0, 1'b1, 1'b0);
    repeat (6) step(1'b0, 1'b0, 1'b0);
    check("match_over_held", 9'd0, 3'd0, 3'd7, 2'b01, 1'b0, 1'b1);
    step(1'b0, 1'b0, 1'b1);
    check("new_game_exit", Ctr, 3'd0, 3'd0, 2'b00, 1'b1, 1'b0);

    // p1 reaches score 3; async reset lands mid-hold.
    for (int r = 1; r <= 3; r++) begin
      repeat (5) step(1'b1, 1'b0, 1'b0);
      if (r < 3) repeat (4) step(1'b0, 1'b0, 1'b0);
    end
    check("p1_third_win", 9'd0, 3'd3, 3'd0, 2'b10, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0);
    #3;
    reset_n = 1'b0;
    #1;
    check("async_reset", Ctr, 3'd0, 3'd0, 2'b00, 1'b1, 1'b0);
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    check("reset_held", Ctr, 3'd0, 3'd0, 2'b00, 1'b1, 1'b0);
    step(1'b1, 1'b0, 1'b0);
    check("play_after_reset", 9'b000100000, 3'd0, 3'd0, 2'b00, 1'b1, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
